// File: rtl/alu_pipe.sv
// Registered 6502-class ALU with valid/ready handshakes on both sides.
// Binary ops complete in one cycle. Decimal ADC/SBC take one extra cycle:
// the operands are staged and the nibble-serial correction runs in ADJ.
//
// state | meaning
// IDLE  | no result held
// ADJ   | decimal correction pending
// DONE  | result held
module alu_pipe #(
   parameter int WIDTH      = 8,
   parameter int DECIMAL_EN = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             v_in,
   input  logic             dec_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             n_out,
   output logic             z_out,
   output logic             c_out,
   output logic             v_out
);

   localparam int MSB = WIDTH - 1;
   localparam int NIB = WIDTH / 4;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   localparam logic [3:0] OP_ADC = 4'd0;
   localparam logic [3:0] OP_SBC = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_ORA = 4'd3;
   localparam logic [3:0] OP_EOR = 4'd4;
   localparam logic [3:0] OP_ASL = 4'd5;
   localparam logic [3:0] OP_LSR = 4'd6;
   localparam logic [3:0] OP_ROL = 4'd7;
   localparam logic [3:0] OP_ROR = 4'd8;
   localparam logic [3:0] OP_CMP = 4'd9;
   localparam logic [3:0] OP_INC = 4'd10;
   localparam logic [3:0] OP_DEC = 4'd11;

   typedef enum logic [1:0] {S_IDLE, S_ADJ, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
   logic [WIDTH-1:0] dec_a_q, dec_a_d, dec_b_q, dec_b_d;
   logic             dec_c_q, dec_c_d, dec_sub_q, dec_sub_d, dec_v_q, dec_v_d;

   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic [WIDTH:0]   sum;
   logic             v_add;
   logic [WIDTH-1:0] bin_res;
   logic             bin_n, bin_z, bin_c, bin_v;

   logic [WIDTH-1:0] dec_res;
   logic             dec_cout;
   logic             k;
   logic [3:0]       ai, bi, digit;
   logic [4:0]       t5;
   logic [5:0]       t6;

   logic             accept, is_dec;

   // Binary datapath: SBC and CMP share the adder with b inverted.
   always_comb begin
      b_eff   = (op == OP_SBC || op == OP_CMP) ? ~b : b;
      cin_eff = (op == OP_CMP) ? 1'b1 : c_in;
      sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
      v_add   = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
      bin_res = a;
      bin_c   = c_in;
      bin_v   = v_in;
      case (op)
         OP_ADC, OP_SBC: begin
            bin_res = sum[MSB:0];
            bin_c   = sum[WIDTH];
            bin_v   = v_add;
         end
         OP_AND: bin_res = a & b;
         OP_ORA: bin_res = a | b;
         OP_EOR: bin_res = a ^ b;
         OP_ASL: begin
            bin_res = {a[MSB-1:0], 1'b0};
            bin_c   = a[MSB];
         end
         OP_LSR: begin
            bin_res = {1'b0, a[MSB:1]};
            bin_c   = a[0];
         end
         OP_ROL: begin
            bin_res = {a[MSB-1:0], c_in};
            bin_c   = a[MSB];
         end
         OP_ROR: begin
            bin_res = {c_in, a[MSB:1]};
            bin_c   = a[0];
         end
         OP_CMP: bin_c = sum[WIDTH];
         OP_INC: bin_res = a + ONE;
         OP_DEC: bin_res = a - ONE;
         default: bin_res = a;
      endcase
      // CMP reports flags of the difference while passing a through.
      if (op == OP_CMP) begin
         bin_n = sum[MSB];
         bin_z = (sum[MSB:0] == '0);
      end else begin
         bin_n = bin_res[MSB];
         bin_z = (bin_res == '0);
      end
   end

   // Decimal correction on staged operands, nibble-serial from the LSB.
   always_comb begin
      dec_res = '0;
      k       = dec_sub_q ? ~dec_c_q : dec_c_q;
      ai      = '0;
      bi      = '0;
      digit   = '0;
      t5      = '0;
      t6      = '0;
      for (int i = 0; i < NIB; i++) begin
         ai = dec_a_q[4*i +: 4];
         bi = dec_b_q[4*i +: 4];
         if (!dec_sub_q) begin
            t5 = {1'b0, ai} + {1'b0, bi} + {4'b0, k};
            if (t5 > 5'd9) begin
               digit = t5[3:0] + 4'd6;
               k     = 1'b1;
            end else begin
               digit = t5[3:0];
               k     = 1'b0;
            end
         end else begin
            t6 = {2'b0, ai} - {2'b0, bi} - {5'b0, k};
            if (t6[5]) begin
               digit = t6[3:0] - 4'd6;
               k     = 1'b1;
            end else begin
               digit = t6[3:0];
               k     = 1'b0;
            end
         end
         dec_res[4*i +: 4] = digit;
      end
      dec_cout = dec_sub_q ? ~k : k;
   end

   // Handshake, next state and result/flag capture.
   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      n_d       = n_q;
      z_d       = z_q;
      c_d       = c_q;
      v_d       = v_q;
      dec_a_d   = dec_a_q;
      dec_b_d   = dec_b_q;
      dec_c_d   = dec_c_q;
      dec_sub_d = dec_sub_q;
      dec_v_d   = dec_v_q;
      in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
      accept    = in_valid && in_ready;
      is_dec    = (DECIMAL_EN != 0) && dec_in && (op == OP_ADC || op == OP_SBC);
      case (state_q)
         S_ADJ: begin
            state_d  = S_DONE;
            result_d = dec_res;
            n_d      = dec_res[MSB];
            z_d      = (dec_res == '0);
            c_d      = dec_cout;
            v_d      = dec_v_q;
         end
         S_IDLE, S_DONE: begin
            if (accept) begin
               if (is_dec) begin
                  state_d   = S_ADJ;
                  dec_a_d   = a;
                  dec_b_d   = b;
                  dec_c_d   = c_in;
                  dec_sub_d = (op == OP_SBC);
                  dec_v_d   = bin_v;
               end else begin
                  state_d  = S_DONE;
                  result_d = bin_res;
                  n_d      = bin_n;
                  z_d      = bin_z;
                  c_d      = bin_c;
                  v_d      = bin_v;
               end
            end else if (state_q == S_DONE && out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset discards any pending op.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         result_q  <= '0;
         n_q       <= 1'b0;
         z_q       <= 1'b0;
         c_q       <= 1'b0;
         v_q       <= 1'b0;
         dec_a_q   <= '0;
         dec_b_q   <= '0;
         dec_c_q   <= 1'b0;
         dec_sub_q <= 1'b0;
         dec_v_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         n_q       <= n_d;
         z_q       <= z_d;
         c_q       <= c_d;
         v_q       <= v_d;
         dec_a_q   <= dec_a_d;
         dec_b_q   <= dec_b_d;
         dec_c_q   <= dec_c_d;
         dec_sub_q <= dec_sub_d;
         dec_v_q   <= dec_v_d;
      end
   end

   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign n_out     = n_q;
   assign z_out     = z_q;
   assign c_out     = c_q;
   assign v_out     = v_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: 8-bit decimal-capable instance driven through a
// scoreboard, plus a 16-bit binary-only instance checked directly.
module tb_alu_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, in_valid, in_ready, c_in, v_in, dec_in;
   logic       out_valid, out_ready, n_out, z_out, c_out, v_out;
   logic [3:0] op;
   logic [7:0] a, b, result;

   logic        in_valid16, in_ready16, c_in16, v_in16, dec_in16;
   logic        out_valid16, out_ready16, n16, z16, c16, v16;
   logic [3:0]  op16;
   logic [15:0] a16, b16, result16;

   alu_pipe #(.WIDTH(8), .DECIMAL_EN(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .c_in(c_in), .v_in(v_in), .dec_in(dec_in),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .n_out(n_out), .z_out(z_out), .c_out(c_out), .v_out(v_out)
   );

   alu_pipe #(.WIDTH(16), .DECIMAL_EN(0)) dut16 (
      .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
      .op(op16), .a(a16), .b(b16), .c_in(c_in16), .v_in(v_in16), .dec_in(dec_in16),
      .out_valid(out_valid16), .out_ready(out_ready16), .result(result16),
      .n_out(n16), .z_out(z16), .c_out(c16), .v_out(v16)
   );

   int n_checks = 0;
   int n_errors = 0;

   string      tag_q[$];
   logic [11:0] exp_q[$];
   string      mon_tag;
   logic [11:0] mon_exp;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: compare every consumed result against the oldest expectation.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         check_val("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_tag = tag_q.pop_front();
            mon_exp = exp_q.pop_front();
            check_val(mon_tag, 32'({result, n_out, z_out, c_out, v_out}), 32'(mon_exp));
         end
      end
   end

   // Present an op, wait (bounded) for acceptance, optionally record its expectation.
   task automatic send(input logic [3:0] f_op, input logic [7:0] f_a, input logic [7:0] f_b,
                       input logic f_c, input logic f_v, input logic f_d, input bit push,
                       input string tag, input logic [11:0] e, output int waits);
      op = f_op; a = f_a; b = f_b; c_in = f_c; v_in = f_v; dec_in = f_d;
      in_valid = 1'b1;
      waits = 0;
      @(negedge clk);
      while (!in_ready && waits < 20) begin
         waits++;
         @(negedge clk);
      end
      if (!in_ready) check_val({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
      if (push) begin
         tag_q.push_back(tag);
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Binary op: expected to be accepted without stall when the pipe is flowing.
   task automatic bin(input logic [3:0] f_op, input logic [7:0] f_a, input logic [7:0] f_b,
                      input logic f_c, input logic f_v, input logic f_d,
                      input logic [7:0] e_res, input logic [3:0] e_nzcv, input string tag);
      int w;
      send(f_op, f_a, f_b, f_c, f_v, f_d, 1'b1, tag, {e_res, e_nzcv}, w);
      check_val({tag, "_stall"}, 32'(w), 32'd0);
   endtask

   task automatic dec(input logic [3:0] f_op, input logic [7:0] f_a, input logic [7:0] f_b,
                      input logic f_c, input logic [7:0] e_res, input logic [3:0] e_nzcv,
                      input string tag);
      int w;
      send(f_op, f_a, f_b, f_c, 1'b0, 1'b1, 1'b1, tag, {e_res, e_nzcv}, w);
   endtask

   initial begin
      int w;
      reset = 1'b1; out_ready = 1'b1;
      in_valid = 1'b1; op = 4'd0; a = 8'h11; b = 8'h22; c_in = 1'b0; v_in = 1'b0; dec_in = 1'b0;
      in_valid16 = 1'b1; op16 = 4'd0; a16 = 16'h1234; b16 = 16'h1111; c_in16 = 1'b0;
      v_in16 = 1'b0; dec_in16 = 1'b0; out_ready16 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_in_ready", 32'(in_ready), 32'd1);
      check_val("rst_result_flags", 32'({result, n_out, z_out, c_out, v_out}), 32'd0);
      check_val("rst16_state", 32'({out_valid16, in_ready16, result16, n16, z16, c16, v16}), 32'h10000 << 4);
      in_valid = 1'b0; in_valid16 = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      check_val("rst_in_valid_ignored", 32'(out_valid), 32'd0);

      // Binary ops, back to back.
      bin(4'd0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0, 8'hA0, 4'b1001, "adc_overflow");
      check_val("bin_latency", 32'(out_valid), 32'd1);
      bin(4'd1, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 8'hFF, 4'b1000, "sbc_borrow");
      bin(4'd9, 8'h40, 8'h40, 1'b0, 1'b1, 1'b0, 8'h40, 4'b0111, "cmp_eq");
      bin(4'd9, 8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 8'h10, 4'b1000, "cmp_lt");
      bin(4'd9, 8'h20, 8'h10, 1'b0, 1'b1, 1'b0, 8'h20, 4'b0011, "cmp_gt");
      bin(4'd2, 8'hF0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h30, 4'b0011, "and_dec_ignored");
      bin(4'd3, 8'h80, 8'h01, 1'b0, 1'b0, 1'b0, 8'h81, 4'b1000, "ora");
      bin(4'd4, 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0110, "eor_zero");
      bin(4'd5, 8'h81, 8'h00, 1'b0, 1'b1, 1'b0, 8'h02, 4'b0011, "asl");
      bin(4'd6, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0110, "lsr");
      bin(4'd7, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 4'b0010, "rol");
      bin(4'd8, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h80, 4'b1010, "ror");
      bin(4'd10, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0110, "inc_wrap");
      bin(4'd10, 8'h41, 8'h00, 1'b0, 1'b0, 1'b0, 8'h42, 4'b0000, "inc");
      bin(4'd11, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'hFF, 4'b1001, "dec_wrap");
      bin(4'd13, 8'h7F, 8'h55, 1'b1, 1'b0, 1'b0, 8'h7F, 4'b0010, "pass");
      bin(4'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 4'b1001, "adc_pos_ovf");
      bin(4'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0110, "adc_carry");
      bin(4'd1, 8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 8'h7F, 4'b0011, "sbc_neg_ovf");

      // Decimal ops: extra adjust cycle with in_ready low.
      dec(4'd0, 8'h58, 8'h46, 1'b1, 8'h05, 4'b0011, "dadc_58_46");
      check_val("dec_adj_out_valid", 32'(out_valid), 32'd0);
      check_val("dec_adj_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check_val("dec_latency", 32'(out_valid), 32'd1);
      dec(4'd1, 8'h12, 8'h21, 1'b1, 8'h91, 4'b1000, "dsbc_12_21");
      dec(4'd0, 8'h99, 8'h01, 1'b0, 8'h00, 4'b0110, "dadc_99_01");
      dec(4'd1, 8'h00, 8'h01, 1'b1, 8'h99, 4'b1000, "dsbc_00_01");
      dec(4'd0, 8'h0F, 8'h00, 1'b0, 8'h15, 4'b0000, "dadc_nonbcd");
      dec(4'd1, 8'h46, 8'h12, 1'b1, 8'h34, 4'b0010, "dsbc_no_borrow");
      repeat (4) @(posedge clk);
      #1;

      // Backpressure: result held, new op stalled until the consumer takes it.
      out_ready = 1'b0;
      send(4'd4, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, "bp_held", {8'hFF, 4'b1000}, w);
      op = 4'd3; a = 8'h01; b = 8'h02; c_in = 1'b1; v_in = 1'b1; dec_in = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_val("bp_in_ready_low", 32'(in_ready), 32'd0);
         check_val("bp_result_stable", 32'({out_valid, result, n_out, z_out, c_out, v_out}),
                   32'({1'b1, 8'hFF, 4'b1000}));
      end
      out_ready = 1'b1;
      send(4'd3, 8'h01, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1, "bp_next", {8'h03, 4'b0011}, w);
      check_val("bp_same_cycle_accept", 32'(w), 32'd0);
      check_val("bp_next_valid", 32'(out_valid), 32'd1);

      // Reset while the decimal adjust is pending: the op must vanish.
      send(4'd0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, "rst_adj", 12'h0, w);
      reset = 1'b1;
      in_valid = 1'b1; op = 4'd0; a = 8'h01; b = 8'h01; dec_in = 1'b0;
      @(posedge clk); #1;
      check_val("rst_adj_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_adj_in_ready", 32'(in_ready), 32'd1);
      check_val("rst_adj_result", 32'({result, n_out, z_out, c_out, v_out}), 32'd0);
      in_valid = 1'b0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_adj_never_output", 32'(out_valid), 32'd0);

      // 16-bit, decimal disabled: dec_in ignored, single-cycle latency.
      op16 = 4'd0; a16 = 16'h7FFF; b16 = 16'h0001; c_in16 = 1'b0; v_in16 = 1'b0; dec_in16 = 1'b1;
      in_valid16 = 1'b1;
      @(negedge clk);
      check_val("w16_in_ready", 32'(in_ready16), 32'd1);
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      check_val("w16_adc", 32'({out_valid16, result16, n16, z16, c16, v16}),
                32'({1'b1, 16'h8000, 4'b1001}));
      op16 = 4'd1; a16 = 16'h0000; b16 = 16'h0001; c_in16 = 1'b1; dec_in16 = 1'b1;
      in_valid16 = 1'b1;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      check_val("w16_sbc", 32'({out_valid16, result16, n16, z16, c16, v16}),
                32'({1'b1, 16'hFFFF, 4'b1000}));

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check_val("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
